// File: rtl/pipe_control_unit.sv
// Pipelined MIPS main control: ID decode feeds the ID/EX, EX/MEM and MEM/WB control registers, one stage per cycle (ex +1, mem +2, wb +3).
// No handshake: freeze holds all stages, and a load-use stall or flush puts a bubble into ID/EX while later stages drain.
module pipe_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter bit EN_BNE     = 1'b1,
  parameter bit EN_JAL     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush_id,
  input  logic                  freeze,
  output logic                  id_branch,
  output logic                  id_branch_ne,
  output logic                  id_jump,
  output logic                  load_use_stall,
  output logic                  ex_alu_src,
  output logic [2:0]            ex_alu_op,
  output logic                  ex_zero_ext,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  ex_illegal,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  mem_reg_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic                  wb_link,
  output logic [REG_ADDR_W-1:0] wb_dest
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef struct packed {
    logic                  aluSrc;
    logic [2:0]            aluOp;
    logic                  zeroExt;
    logic                  illegal;
    logic                  memRead;
    logic                  memWrite;
    logic                  regWrite;
    logic                  memToReg;
    logic                  link;
    logic [REG_ADDR_W-1:0] dest;
  } exCtrl_t;

  typedef struct packed {
    logic                  memRead;
    logic                  memWrite;
    logic                  regWrite;
    logic                  memToReg;
    logic                  link;
    logic [REG_ADDR_W-1:0] dest;
  } memCtrl_t;

  typedef struct packed {
    logic                  regWrite;
    logic                  memToReg;
    logic                  link;
    logic [REG_ADDR_W-1:0] dest;
  } wbCtrl_t;

  exCtrl_t  dec;
  exCtrl_t  idEx;
  memCtrl_t exMem;
  wbCtrl_t  memWb;
  logic     usesRt;
  logic     isBeq;
  logic     isBne;
  logic     isJump;

  always_comb begin
    dec    = '0;
    usesRt = 1'b0;
    isBeq  = 1'b0;
    isBne  = 1'b0;
    isJump = 1'b0;
    case (id_opcode)
      OP_R: begin
        dec.aluOp    = 3'b010;
        dec.regWrite = 1'b1;
        dec.dest     = id_rd;
        usesRt       = 1'b1;
      end
      OP_LW: begin
        dec.aluSrc   = 1'b1;
        dec.memRead  = 1'b1;
        dec.memToReg = 1'b1;
        dec.regWrite = 1'b1;
        dec.dest     = id_rt;
      end
      OP_SW: begin
        dec.aluSrc   = 1'b1;
        dec.memWrite = 1'b1;
        usesRt       = 1'b1;
      end
      OP_ADDI: begin
        dec.aluSrc   = 1'b1;
        dec.regWrite = 1'b1;
        dec.dest     = id_rt;
      end
      OP_ANDI: begin
        dec.aluSrc   = 1'b1;
        dec.aluOp    = 3'b011;
        dec.zeroExt  = 1'b1;
        dec.regWrite = 1'b1;
        dec.dest     = id_rt;
      end
      OP_ORI: begin
        dec.aluSrc   = 1'b1;
        dec.aluOp    = 3'b100;
        dec.zeroExt  = 1'b1;
        dec.regWrite = 1'b1;
        dec.dest     = id_rt;
      end
      OP_SLTI: begin
        dec.aluSrc   = 1'b1;
        dec.aluOp    = 3'b101;
        dec.regWrite = 1'b1;
        dec.dest     = id_rt;
      end
      OP_BEQ: begin
        dec.aluOp = 3'b001;
        usesRt    = 1'b1;
        isBeq     = 1'b1;
      end
      OP_BNE: begin
        if (EN_BNE) begin
          dec.aluOp = 3'b001;
          usesRt    = 1'b1;
          isBne     = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_J: isJump = 1'b1;
      OP_JAL: begin
        if (EN_JAL) begin
          isJump       = 1'b1;
          dec.regWrite = 1'b1;
          dec.link     = 1'b1;
          dec.dest     = REG_ADDR_W'(31);
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // $0 is hard-wired; never let a write to it reach the register file or forwarding
    if (dec.dest == '0) dec.regWrite = 1'b0;
  end

  assign id_branch    = isBeq;
  assign id_branch_ne = isBne;
  assign id_jump      = isJump;

  assign load_use_stall = idEx.memRead && (idEx.dest != '0) &&
                          ((idEx.dest == id_rs) || (usesRt && (idEx.dest == id_rt)));

  always_ff @(posedge clk) begin
    if (reset) begin
      idEx  <= '0;
      exMem <= '0;
      memWb <= '0;
    end else if (!freeze) begin
      idEx  <= (load_use_stall || flush_id) ? '0 : dec;
      exMem <= '{memRead:  idEx.memRead,  memWrite: idEx.memWrite,
                 regWrite: idEx.regWrite, memToReg: idEx.memToReg,
                 link:     idEx.link,     dest:     idEx.dest};
      memWb <= '{regWrite: exMem.regWrite, memToReg: exMem.memToReg,
                 link:     exMem.link,     dest:     exMem.dest};
    end
  end

  assign ex_alu_src    = idEx.aluSrc;
  assign ex_alu_op     = idEx.aluOp;
  assign ex_zero_ext   = idEx.zeroExt;
  assign ex_dest       = idEx.dest;
  assign ex_illegal    = idEx.illegal;
  assign mem_read      = exMem.memRead;
  assign mem_write     = exMem.memWrite;
  assign mem_dest      = exMem.dest;
  assign mem_reg_write = exMem.regWrite;
  assign wb_reg_write  = memWb.regWrite;
  assign wb_mem_to_reg = memWb.memToReg;
  assign wb_link       = memWb.link;
  assign wb_dest       = memWb.dest;

endmodule
